// File: rtl/wb_host_master.sv
// ============================================================================
//  Module   : wb_host_master
//  Function : Wishbone classic master that issues one single access per command
//             and returns read data or a timeout error.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_host_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERRCNT_W       = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [31:0]         cmd_adr,
  input  logic [31:0]         cmd_dat,
  input  logic [3:0]          cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic [31:0]         wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [TO_W-1:0] to_cnt_q;

  assign cmd_ready = (state_q == S_IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      err_count <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            to_cnt_q  <= '0;
            state_q   <= S_BUS;
          end
        end
        S_BUS: begin
          // An ack in the final allowed cycle still completes the access normally.
          if (wbm_ack_i || (to_cnt_q == TO_LAST)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b1;
            state_q   <= S_RESP;
            if (wbm_ack_i) begin
              rsp_dat <= wbm_we_o ? 32'd0 : wbm_dat_i;
              rsp_err <= 1'b0;
            end else begin
              rsp_dat <= 32'd0;
              rsp_err <= 1'b1;
              if (err_count != {ERRCNT_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
              end
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_host_master.sv
// ============================================================================
//  Module   : tb_wb_host_master
//  Function : Self-checking bench for wb_host_master with a simple slave model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_host_master;

  localparam int TO = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0]   cmd_adr = '0, cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0]   rsp_dat;
  logic          cyc, stb, wbm_we;
  logic [3:0]    wbm_sel;
  logic [31:0]   wbm_adr, wbm_dat_o, wbm_dat_i;
  logic          ack;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack),
    .err_count(err_count)
  );

  // Slave model: acks after slv_delay full cycles of strobe (0 = same cycle).
  logic        slv_en = 1'b0;
  int          slv_delay = 0;
  int          slv_cnt = 0;
  logic [31:0] slv_rdata = '0;
  logic        spur_ack = 1'b0;

  assign ack       = spur_ack | (slv_en && cyc && stb && (slv_cnt == slv_delay));
  assign wbm_dat_i = slv_rdata;

  always @(posedge clk) slv_cnt <= cyc ? slv_cnt + 1 : 0;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_errcnt = 0;

  // Observations of the last transaction
  int          o_lat, o_cychi, o_hold_bad;
  logic        o_to, o_err, o_clear_bad;
  logic [31:0] o_dat;

  // Drives one command and watches it until the first rsp_valid; starts and ends on a negedge.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    int guard = 0;
    o_to = 1'b0; o_lat = 0; o_cychi = 0; o_hold_bad = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      o_to = 1'b1;
      return;
    end
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    do begin
      @(negedge clk);
      o_lat++;
      if (cyc) begin
        o_cychi++;
        if (!stb || wbm_we !== we || wbm_adr !== adr || wbm_dat_o !== dat || wbm_sel !== sel)
          o_hold_bad++;
      end
    end while (!rsp_valid && o_lat < 100);
    if (!rsp_valid) o_to = 1'b1;
    o_dat = rsp_dat;
    o_err = rsp_err;
    o_clear_bad = cyc | stb | wbm_we | (wbm_sel != 0) | (wbm_adr != 0) | (wbm_dat_o != 0);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_tests++; if ({cyc, stb, wbm_we, rsp_valid, rsp_err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {cyc, stb, wbm_we, rsp_valid, rsp_err}); end
    n_tests++; if ({wbm_adr, wbm_dat_o, wbm_sel, rsp_dat} !== '0) begin n_fail++; $display("FAIL reset_data: adr %h dat %h sel %h rsp %h want 0", wbm_adr, wbm_dat_o, wbm_sel, rsp_dat); end
    n_tests++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1 || cyc !== 1'b0) begin n_fail++; $display("FAIL reset_release: ready %b cyc %b want 1 0", cmd_ready, cyc); end
    mdl_errcnt = 0;
  endtask

  task automatic test_write;
    slv_en = 1'b1; slv_delay = 1;
    run_txn(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF);
    n_tests++; if (o_to) begin n_fail++; $display("FAIL write_wait: got no response want response"); end
    n_tests++; if (o_cychi !== 2) begin n_fail++; $display("FAIL write_cyc_len: got %0d want 2", o_cychi); end
    n_tests++; if (o_hold_bad !== 0) begin n_fail++; $display("FAIL write_bus_hold: got %0d bad cycles want 0", o_hold_bad); end
    n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", o_lat); end
    n_tests++; if (o_err !== 1'b0 || o_dat !== 32'h0) begin n_fail++; $display("FAIL write_rsp: err %b dat %h want 0 0", o_err, o_dat); end
    n_tests++; if (o_clear_bad !== 1'b0) begin n_fail++; $display("FAIL write_bus_clear: got %b want 0", o_clear_bad); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL write_rsp_done: valid %b ready %b want 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read;
    slv_en = 1'b1; slv_delay = 0; slv_rdata = 32'h6745_2301;
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    n_tests++; if (o_dat !== 32'h6745_2301 || o_err !== 1'b0) begin n_fail++; $display("FAIL read_rsp: dat %h err %b want 67452301 0", o_dat, o_err); end
    n_tests++; if (o_lat !== 2 || o_cychi !== 1) begin n_fail++; $display("FAIL read_timing: lat %0d cyc %0d want 2 1", o_lat, o_cychi); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    slv_en = 1'b0;
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3);
    n_tests++; if (o_cychi !== TO) begin n_fail++; $display("FAIL timeout_cyc_len: got %0d want %0d", o_cychi, TO); end
    n_tests++; if (o_err !== 1'b1 || o_dat !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp: err %b dat %h want 1 0", o_err, o_dat); end
    n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL timeout_errcnt: got %0d want 1", err_count); end
    mdl_errcnt = 1;
    slv_en = 1'b1; slv_delay = TO - 1; slv_rdata = 32'hCAFE_0001;
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    n_tests++; if (o_cychi !== TO || o_err !== 1'b0 || o_dat !== 32'hCAFE_0001) begin n_fail++; $display("FAIL late_ack: cyc %0d err %b dat %h want %0d 0 cafe0001", o_cychi, o_err, o_dat, TO); end
    n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL late_ack_errcnt: got %0d want 1", err_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] d0;
    int bad = 0;
    slv_en = 1'b1; slv_delay = 2; slv_rdata = $urandom;
    rsp_ready = 1'b0;
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    d0 = o_dat;
    n_tests++; if (d0 !== slv_rdata) begin n_fail++; $display("FAIL bp_first: got %h want %h", d0, slv_rdata); end
    for (int i = 0; i < 5; i++) begin
      spur_ack  = (i == 2);
      cmd_valid = (i >= 1);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== d0 || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || cyc !== 1'b0) bad++;
    end
    spur_ack = 1'b0; cmd_valid = 1'b0;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid %b ready %b cyc %b want 0 1 0", rsp_valid, cmd_ready, cyc); end
    n_tests++; if (err_count !== EW'(mdl_errcnt)) begin n_fail++; $display("FAIL bp_errcnt: got %0d want %0d", err_count, mdl_errcnt); end
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      logic        we, exp_to;
      logic [31:0] adr, dat, exp_dat;
      logic [3:0]  sel;
      int          exp_cyc;
      we = 1'($urandom); adr = $urandom; dat = $urandom; sel = 4'($urandom);
      slv_en = ($urandom_range(0, 4) != 0);
      slv_delay = $urandom_range(0, TO + 2);
      slv_rdata = $urandom;
      exp_to  = !slv_en || (slv_delay >= TO);
      exp_cyc = exp_to ? TO : slv_delay + 1;
      exp_dat = (exp_to || we) ? 32'h0 : slv_rdata;
      if (exp_to && mdl_errcnt < 255) mdl_errcnt++;
      run_txn(we, adr, dat, sel);
      if (o_to || o_cychi != exp_cyc || o_lat != exp_cyc + 1 || o_hold_bad != 0 || o_clear_bad ||
          o_err !== exp_to || o_dat !== exp_dat || err_count !== EW'(mdl_errcnt)) begin
        bad++;
        $display("FAIL random_txn %0d: cyc %0d lat %0d err %b dat %h cnt %0d want cyc %0d lat %0d err %b dat %h cnt %0d",
                 i, o_cychi, o_lat, o_err, o_dat, err_count, exp_cyc, exp_cyc + 1, exp_to, exp_dat, mdl_errcnt);
      end
    end
    n_tests++; if (bad != 0) n_fail++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    slv_en = 1'b0; slv_rdata = 32'h1234_5678;
    cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (cyc !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: cyc %b want 1", cyc); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({cyc, stb, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL midrst_async: got %b want 000", {cyc, stb, rsp_valid}); end
    @(negedge clk);
    rst = 1'b0;
    mdl_errcnt = 0;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1 || err_count !== '0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: ready %b cnt %0d valid %b want 1 0 0", cmd_ready, err_count, rsp_valid); end
    slv_en = 1'b1; slv_delay = 1;
    run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    n_tests++; if (o_dat !== 32'h1234_5678 || o_err !== 1'b0 || o_cychi !== 2) begin n_fail++; $display("FAIL midrst_next: dat %h err %b cyc %0d want 12345678 0 2", o_dat, o_err, o_cychi); end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int bad = 0;
    slv_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom));
      if (o_to || o_err !== 1'b1) bad++;
      if (mdl_errcnt < 255) mdl_errcnt++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sat_responses: got %0d bad want 0", bad); end
    n_tests++; if (err_count !== 8'd255 || mdl_errcnt != 255) begin n_fail++; $display("FAIL sat_errcnt: got %0d want 255", err_count); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
